// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage hazard request bundle and the forward/stall responses for the EX stage.
interface hazard_forward_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_flush;
  logic              stall;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_regwrite, id_memread, id_flush,
    input  stall, forward_a, forward_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_regwrite, id_memread, id_flush,
    output stall, forward_a, forward_b, stall_count
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// EX-stage operand forward selects and load-use stall for the 5-stage MIPS pipeline,
// driven from a shadow EX/MEM/WB record pipeline.
module hazard_forward_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  hazard_forward_ctrl_if.slave   bus
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
  } rec_t;

  rec_t ex_rec, mem_rec, wb_rec;
  logic ex_writer, mem_writer;
  logic stall, id_advance;
  logic [1:0] fwd_a_next, fwd_b_next;
  logic [1:0] forward_a, forward_b;
  logic [CNT_W-1:0] stall_count;

  assign ex_writer  = ex_rec.valid  & ex_rec.regwrite  & (ex_rec.dest  != '0);
  assign mem_writer = mem_rec.valid & mem_rec.regwrite & (mem_rec.dest != '0);

  assign stall = bus.id_valid & ~bus.id_flush & ex_writer & ex_rec.memread &
                 ((bus.id_uses_rs & (bus.id_rs == ex_rec.dest)) |
                  (bus.id_uses_rt & (bus.id_rt == ex_rec.dest)));

  assign id_advance = bus.id_valid & ~bus.id_flush & ~stall;

  // Newest producer (EX) takes priority over the older one in MEM.
  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (bus.id_uses_rs) begin
      if (ex_writer && (bus.id_rs == ex_rec.dest))        fwd_a_next = 2'b01;
      else if (mem_writer && (bus.id_rs == mem_rec.dest)) fwd_a_next = 2'b10;
    end
    if (bus.id_uses_rt) begin
      if (ex_writer && (bus.id_rt == ex_rec.dest))        fwd_b_next = 2'b01;
      else if (mem_writer && (bus.id_rt == mem_rec.dest)) fwd_b_next = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rec      <= '0;
      mem_rec     <= '0;
      wb_rec      <= '0;
      forward_a   <= 2'b00;
      forward_b   <= 2'b00;
      stall_count <= '0;
    end else begin
      wb_rec  <= mem_rec;
      mem_rec <= ex_rec;
      if (id_advance) begin
        ex_rec    <= '{valid: 1'b1, dest: bus.id_dest,
                       regwrite: bus.id_regwrite, memread: bus.id_memread};
        forward_a <= fwd_a_next;
        forward_b <= fwd_b_next;
      end else begin
        ex_rec    <= '0;
        forward_a <= 2'b00;
        forward_b <= 2'b00;
      end
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  assign bus.stall       = stall;
  assign bus.forward_a   = forward_a;
  assign bus.forward_b   = forward_b;
  assign bus.stall_count = stall_count;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl built with a 4-bit stall counter.
module tb_hazard_forward_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_AW(5), .CNT_W(4)) bus ();

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic fl);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_dest     = dest;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_flush    = fl;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nop();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    // A load-like request in ID must not stall while records are invalid
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.forward_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got=%b exp=00", bus.forward_a); end
    checks++; if (bus.forward_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got=%b exp=00", bus.forward_b); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.stall_count); end
    apply_reset();
  endtask

  task automatic test_ex_forward();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); // add r3,r1,r2
    tick();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); // sub r4,r3,r5
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL exfwd_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.forward_a !== 2'b01) begin errors++; $display("FAIL exfwd_a got=%b exp=01", bus.forward_a); end
    checks++; if (bus.forward_b !== 2'b00) begin errors++; $display("FAIL exfwd_b got=%b exp=00", bus.forward_b); end
  endtask

  task automatic test_mem_forward();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); // add r3
    tick();
    nop();
    tick();
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); // or r6,r1,r3
    tick();
    checks++; if (bus.forward_a !== 2'b00) begin errors++; $display("FAIL memfwd_a got=%b exp=00", bus.forward_a); end
    checks++; if (bus.forward_b !== 2'b10) begin errors++; $display("FAIL memfwd_b got=%b exp=10", bus.forward_b); end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); // lw r2,(r1)
    tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); // add r7,r2,r2
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd got=%b/%b exp=00/00", bus.forward_a, bus.forward_b); end
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", bus.stall_count); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.forward_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a got=%b exp=10", bus.forward_a); end
    checks++; if (bus.forward_b !== 2'b10) begin errors++; $display("FAIL lu_fwd_b got=%b exp=10", bus.forward_b); end
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_count_hold got=%0d exp=1", bus.stall_count); end
  endtask

  task automatic test_reg0_and_newest();
    apply_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); // lw r0
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); // sub r4,r0,r0
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL r0_fwd got=%b/%b exp=00/00", bus.forward_a, bus.forward_b); end
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); // add r3
    tick();
    drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); // add r3 again
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); // uses r3 twice
    tick();
    checks++; if (bus.forward_a !== 2'b01 || bus.forward_b !== 2'b01) begin errors++; $display("FAIL newest_fwd got=%b/%b exp=01/01", bus.forward_a, bus.forward_b); end
    // Unused sources never forward even when the register matches
    drive(1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL unused_fwd got=%b/%b exp=00/00", bus.forward_a, bus.forward_b); end
  endtask

  task automatic test_flush();
    apply_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); // lw r2
    tick();
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1); // lw r2,(r2), flushed
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.forward_a !== 2'b00) begin errors++; $display("FAIL flush_fwd_a got=%b exp=00", bus.forward_a); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.stall_count); end
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); // consumer of r2
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_bubble_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.forward_a !== 2'b10) begin errors++; $display("FAIL flush_after_fwd got=%b exp=10", bus.forward_a); end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); // lw r2,(r1)
    tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();                                                       // one stall counted
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); // lw r2,(r2)
    tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.forward_a !== 2'b10 || bus.stall_count !== 4'd1) begin errors++; $display("FAIL pre_reset got=%b/%b/%0d exp=1/10/1", bus.stall, bus.forward_a, bus.stall_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL midrst_fwd got=%b/%b exp=00/00", bus.forward_a, bus.forward_b); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", bus.stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tick();
    checks++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL postrst_fwd got=%b/%b exp=00/00", bus.forward_a, bus.forward_b); end
  endtask

  task automatic test_saturate();
    int seen = 0;
    apply_reset();
    // Self-dependent load alternates enter/stall: 38 cycles give 19 stalls
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 38; i++) begin
      #1;
      if (bus.stall === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 19) begin errors++; $display("FAIL sat_stall_cycles got=%0d exp=19", seen); end
    checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_count got=%0d exp=15", bus.stall_count); end
  endtask

  initial begin
    nop();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_reg0_and_newest();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
